// File: rtl/insn_spm.sv
// insn_spm: dual-port instruction/data scratchpad with a post-reset clear engine.
//
// Ports:
//   clk, reset        - clock and asynchronous active-high reset
//   if_spm_*          - port A (instruction fetch): word addr, active-low strobe,
//                       direction (READ=1, WRITE=0), write data, registered read data
//   mem_spm_*         - port B (MEM stage): as port A plus per-byte-lane enables
//   spm_busy          - high while the clear engine is zeroing the array
//
// Both ports index the array with the low ADDR_W bits of the word address, so
// upper address bits alias. Reads are read-first. When both ports write the
// same word in one cycle, B-enabled lanes take B's data and the rest take A's.
module insn_spm #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] if_spm_addr,
  input  logic        if_spm_as_,
  input  logic        if_spm_rw,
  input  logic [31:0] if_spm_wr_data,
  output logic [31:0] if_spm_rd_data,
  input  logic [29:0] mem_spm_addr,
  input  logic        mem_spm_as_,
  input  logic        mem_spm_rw,
  input  logic [3:0]  mem_spm_be,
  input  logic [31:0] mem_spm_wr_data,
  output logic [31:0] mem_spm_rd_data,
  output logic        spm_busy
);

  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    CLEAR = 2'd1,
    READY = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [31:0]         mem [DEPTH];

  logic [ADDR_W-1:0]   a_idx;
  logic [ADDR_W-1:0]   b_idx;
  logic                a_acc;
  logic                a_wr;
  logic                b_acc;
  logic                b_wr;
  logic                ready;
  logic                clr_last;
  logic                unused_addr_bits;

  assign a_idx = if_spm_addr[ADDR_W-1:0];
  assign b_idx = mem_spm_addr[ADDR_W-1:0];
  // Upper address bits are intentionally ignored (aliasing modulo DEPTH).
  assign unused_addr_bits = ^{if_spm_addr[29:ADDR_W], mem_spm_addr[29:ADDR_W]};

  // Access decode: ports are only honoured once the clear has finished.
  always_comb begin
    ready    = (state == READY);
    a_acc    = 1'b0;
    a_wr     = 1'b0;
    b_acc    = 1'b0;
    b_wr     = 1'b0;
    clr_last = (clr_cnt == ADDR_W'(DEPTH - 1));
    if (ready) begin
      a_acc = ~if_spm_as_;
      b_acc = ~mem_spm_as_;
      a_wr  = ~if_spm_as_ & (if_spm_rw == WRITE);
      b_wr  = ~mem_spm_as_ & (mem_spm_rw == WRITE);
    end else begin
      a_acc = 1'b0;
      b_acc = 1'b0;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      INIT:    state_next = CLEAR;
      CLEAR: begin
        if (clr_last) begin
          state_next = READY;
        end else begin
          state_next = CLEAR;
        end
      end
      READY:   state_next = READY;
      default: state_next = INIT;
    endcase
  end

  // FSM state, clear counter and busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      clr_cnt  <= {ADDR_W{1'b0}};
      spm_busy <= 1'b1;
    end else begin
      state    <= state_next;
      spm_busy <= (state_next != READY);
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        clr_cnt <= clr_cnt;
      end
    end
  end

  // Array writes: clear engine, then port A, then port B lanes; later
  // non-blocking writes win, which gives B priority on enabled lanes.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= 32'h0000_0000;
    end else begin
      if (a_wr) begin
        mem[a_idx] <= if_spm_wr_data;
      end
      for (int n = 0; n < 4; n++) begin
        if (b_wr && mem_spm_be[n]) begin
          mem[b_idx][8*n +: 8] <= mem_spm_wr_data[8*n +: 8];
        end
      end
    end
  end

  // Registered read data: any access (read or write) returns the old word;
  // held at zero until the clear engine finishes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_spm_rd_data  <= 32'h0000_0000;
      mem_spm_rd_data <= 32'h0000_0000;
    end else if (!ready) begin
      if_spm_rd_data  <= 32'h0000_0000;
      mem_spm_rd_data <= 32'h0000_0000;
    end else begin
      if (a_acc) begin
        if_spm_rd_data <= mem[a_idx];
      end
      if (b_acc) begin
        mem_spm_rd_data <= mem[b_idx];
      end
    end
  end

endmodule

// File: tb/tb_insn_spm.sv
// Self-checking bench for insn_spm: directed vector table plus hand-written
// reset / clear-engine sequences.
module tb_insn_spm;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] if_spm_addr;
  logic        if_spm_as_;
  logic        if_spm_rw;
  logic [31:0] if_spm_wr_data;
  logic [31:0] if_spm_rd_data;
  logic [29:0] mem_spm_addr;
  logic        mem_spm_as_;
  logic        mem_spm_rw;
  logic [3:0]  mem_spm_be;
  logic [31:0] mem_spm_wr_data;
  logic [31:0] mem_spm_rd_data;
  logic        spm_busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] b_seen;

  typedef struct {
    logic        a_as;
    logic        a_rw;
    logic [29:0] a_addr;
    logic [31:0] a_wd;
    logic        b_as;
    logic        b_rw;
    logic [29:0] b_addr;
    logic [3:0]  b_be;
    logic [31:0] b_wd;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[20];

  insn_spm dut (
    .clk             (clk),
    .reset           (reset),
    .if_spm_addr     (if_spm_addr),
    .if_spm_as_      (if_spm_as_),
    .if_spm_rw       (if_spm_rw),
    .if_spm_wr_data  (if_spm_wr_data),
    .if_spm_rd_data  (if_spm_rd_data),
    .mem_spm_addr    (mem_spm_addr),
    .mem_spm_as_     (mem_spm_as_),
    .mem_spm_rw      (mem_spm_rw),
    .mem_spm_be      (mem_spm_be),
    .mem_spm_wr_data (mem_spm_wr_data),
    .mem_spm_rd_data (mem_spm_rd_data),
    .spm_busy        (spm_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle();
    if_spm_as_      = 1'b1;
    if_spm_rw       = RD;
    if_spm_addr     = 30'd0;
    if_spm_wr_data  = 32'h0;
    mem_spm_as_     = 1'b1;
    mem_spm_rw      = RD;
    mem_spm_addr    = 30'd0;
    mem_spm_be      = 4'h0;
    mem_spm_wr_data = 32'h0;
  endtask

  // Counts rising edges until spm_busy is seen low; bounded.
  task automatic wait_ready(output int n);
    n = 0;
    b_seen = 32'h0;
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk);
      #1;
      n++;
      b_seen = b_seen | mem_spm_rd_data;
      if (!spm_busy) break;
    end
  endtask

  task automatic mid_reset_check(input string tag);
    check({tag, "_a_rd"}, if_spm_rd_data, 32'h0);
    check({tag, "_b_rd"}, mem_spm_rd_data, 32'h0);
    check({tag, "_busy"}, {31'd0, spm_busy}, 32'h1);
  endtask

  initial begin
    int n;
    //            a_as  a_rw a_addr        a_wd           b_as  b_rw b_addr      be    b_wd           exp_a          exp_b
    vecs[0]  = '{1'b0, RD, 30'd0,        32'h0,        1'b1, RD, 30'd0,      4'h0, 32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1'b0, RD, 30'd2047,     32'h0,        1'b1, RD, 30'd0,      4'h0, 32'h0,        32'h0,        32'h0};
    vecs[2]  = '{1'b0, RD, 30'd4095,     32'h0,        1'b1, RD, 30'd0,      4'h0, 32'h0,        32'h0,        32'h0};
    vecs[3]  = '{1'b1, RD, 30'd0,        32'h0,        1'b0, RD, 30'd5,      4'h0, 32'h0,        32'h0,        32'h0};
    vecs[4]  = '{1'b1, RD, 30'd0,        32'h0,        1'b0, WR, 30'd10,     4'hF, 32'h11223344, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, RD, 30'd0,        32'h0,        1'b0, WR, 30'd10,     4'h5, 32'hAABBCCDD, 32'h0,        32'h11223344};
    vecs[6]  = '{1'b0, RD, 30'd10,       32'h0,        1'b1, RD, 30'd0,      4'h0, 32'h0,        32'h11BB33DD, 32'h11223344};
    vecs[7]  = '{1'b0, WR, 30'd20,       32'h0000FFFF, 1'b0, WR, 30'd20,     4'h3, 32'h12345678, 32'h0,        32'h0};
    vecs[8]  = '{1'b0, RD, 30'd20,       32'h0,        1'b1, RD, 30'd0,      4'h0, 32'h0,        32'h00005678, 32'h0};
    vecs[9]  = '{1'b0, WR, 30'd30,       32'h1,        1'b1, RD, 30'd0,      4'h0, 32'h0,        32'h0,        32'h0};
    vecs[10] = '{1'b0, RD, 30'd30,       32'h0,        1'b0, WR, 30'd30,     4'hF, 32'h2,        32'h1,        32'h1};
    vecs[11] = '{1'b1, RD, 30'd0,        32'h0,        1'b0, RD, 30'd30,     4'h0, 32'h0,        32'h1,        32'h2};
    vecs[12] = '{1'b0, RD, 30'd30,       32'h0,        1'b1, RD, 30'd0,      4'h0, 32'h0,        32'h2,        32'h2};
    vecs[13] = '{1'b1, RD, 30'd0,        32'h0,        1'b0, WR, 30'h1000,   4'hF, 32'hCAFEF00D, 32'h2,        32'h0};
    vecs[14] = '{1'b0, RD, 30'd0,        32'h0,        1'b1, RD, 30'd0,      4'h0, 32'h0,        32'hCAFEF00D, 32'h0};
    vecs[15] = '{1'b1, RD, 30'd0,        32'h0,        1'b0, WR, 30'd10,     4'h0, 32'hFFFFFFFF, 32'hCAFEF00D, 32'h11BB33DD};
    vecs[16] = '{1'b1, RD, 30'd0,        32'h0,        1'b0, RD, 30'd10,     4'h0, 32'h0,        32'hCAFEF00D, 32'h11BB33DD};
    vecs[17] = '{1'b0, WR, 30'd40,       32'h89ABCDEF, 1'b1, RD, 30'd0,      4'h0, 32'h0,        32'h0,        32'h11BB33DD};
    vecs[18] = '{1'b1, RD, 30'd0,        32'h0,        1'b0, RD, 30'd40,     4'h0, 32'h0,        32'h0,        32'h89ABCDEF};
    vecs[19] = '{1'b0, RD, 30'h3FFFF028, 32'h0,        1'b0, RD, 30'h2028,   4'h0, 32'h0,        32'h89ABCDEF, 32'h89ABCDEF};

    // Reset with a port-B write pending for the whole clear.
    idle();
    reset = 1'b1;
    mem_spm_as_     = 1'b0;
    mem_spm_rw      = WR;
    mem_spm_addr    = 30'd5;
    mem_spm_be      = 4'hF;
    mem_spm_wr_data = 32'hDEADBEEF;
    #12;
    mid_reset_check("reset");
    @(negedge clk);
    reset = 1'b0;
    wait_ready(n);
    check("clear_edges", n, 32'd4097);
    check("b_rd_during_clear", b_seen, 32'h0);
    idle();

    // Directed vector table, one access cycle per row.
    for (int i = 0; i < 20; i++) begin
      if_spm_as_      = vecs[i].a_as;
      if_spm_rw       = vecs[i].a_rw;
      if_spm_addr     = vecs[i].a_addr;
      if_spm_wr_data  = vecs[i].a_wd;
      mem_spm_as_     = vecs[i].b_as;
      mem_spm_rw      = vecs[i].b_rw;
      mem_spm_addr    = vecs[i].b_addr;
      mem_spm_be      = vecs[i].b_be;
      mem_spm_wr_data = vecs[i].b_wd;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_a", i), if_spm_rd_data, vecs[i].exp_a);
      check($sformatf("vec%0d_b", i), mem_spm_rd_data, vecs[i].exp_b);
    end
    idle();

    // Reset while READY with non-zero read data: outputs clear at once.
    #2;
    reset = 1'b1;
    #1;
    mid_reset_check("ready_reset");
    @(negedge clk);
    reset = 1'b0;

    // Reset again when the clear counter has reached 100.
    repeat (101) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    mid_reset_check("clear_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_ready(n);
    check("reclear_edges", n, 32'd4097);

    // Words written before the resets are zero again.
    if_spm_as_   = 1'b0;
    if_spm_addr  = 30'd40;
    mem_spm_as_  = 1'b0;
    mem_spm_addr = 30'd10;
    @(posedge clk);
    #1;
    check("reclear_a_40", if_spm_rd_data, 32'h0);
    check("reclear_b_10", mem_spm_rd_data, 32'h0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
